// File: rtl/uart_pkg.sv
// Purpose: constants and FSM encoding shared by the UART receiver, baud generator and transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int CLK_FREQ        = 50_000_000;
  localparam int BAUD            = 115200;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for an asynchronous single-bit input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk (clock), rst (sync active-high reset, loads RESET_VAL), d (async in), q (synchronised out).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver driven by a 16x oversample strobe, one-entry valid/ready output register.
// Latency: rx_valid rises 1 clk_50m cycle after the rxclk_en tick that samples the stop bit.
// Backpressure: one byte held until rx_ready; a frame finishing while the byte is unconsumed is dropped and flagged on rx_overrun.
// Ports: clk_50m, rst (sync active-high), rxclk_en (oversample strobe), rx_in (async line),
//        rx_ready / rx_valid / rx_data (output handshake), rx_frame_err / rx_overrun (1-cycle pulses), rx_busy.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int MID_SAMPLE = OVERSAMPLE / 2
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS);

  localparam logic [SCNT_W-1:0] MID_LAST = SCNT_W'(MID_SAMPLE - 1);
  localparam logic [SCNT_W-1:0] OS_LAST  = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_BITS - 1);

  rx_state_t             state;
  logic [SCNT_W-1:0]     sample_cnt;
  logic [BCNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  rx_sync;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk (clk_50m),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_sync)
  );

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state        <= IDLE;
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;

      // Consumer handshake runs every cycle; a frame completing in this same
      // cycle re-asserts rx_valid below, which takes precedence.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (rxclk_en) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state      <= START;
              sample_cnt <= '0;
            end
          end

          START: begin
            if (sample_cnt == MID_LAST) begin
              // Centre of the start bit: still low means a real frame,
              // high means the edge was a glitch.
              sample_cnt <= '0;
              if (!rx_sync) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          DATA: begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == OS_LAST) begin
              // LSB arrives first, so shifting in at the MSB leaves the byte
              // in natural order after the last bit.
              shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end
            end
          end

          STOP: begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == OS_LAST) begin
              if (rx_sync) begin
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  rx_overrun <= 1'b1;
                end
                state <= IDLE;
              end else begin
                rx_frame_err <= 1'b1;
                state        <= WAIT_HIGH;
              end
            end
          end

          WAIT_HIGH: begin
            // A held-low line (break) must return high before a new start edge counts.
            if (rx_sync) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int TICK_DIV  = 27;
  localparam int BIT_CYC   = 16 * TICK_DIV;
  localparam int MID_TICKS = 8;

  logic       clk_50m;
  logic       rst;
  logic       rxclk_en;
  logic       rx_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int n_vec;
  int n_miss;

  // monitor state
  int         fe_cyc;
  int         ov_cyc;
  int         rise_cnt;
  int         rise_bad;
  logic       prev_valid;
  logic [7:0] got_q[$];

  // reference model queue of bytes the consumer should see
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .rxclk_en     (rxclk_en),
    .rx_in        (rx_in),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  // Oversample strobe: one cycle high every TICK_DIV cycles, changed on the falling edge.
  initial begin
    int div;
    div      = 0;
    rxclk_en = 1'b0;
    forever begin
      @(negedge clk_50m);
      rxclk_en = (div == TICK_DIV - 1);
      div      = (div == TICK_DIV - 1) ? 0 : div + 1;
    end
  end

  // Observe outputs just after each rising edge.
  initial begin
    fe_cyc     = 0;
    ov_cyc     = 0;
    rise_cnt   = 0;
    rise_bad   = 0;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk_50m);
      #1;
      if (rx_frame_err === 1'b1) fe_cyc++;
      if (rx_overrun === 1'b1) ov_cyc++;
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
        rise_cnt++;
        // The edge that raised rx_valid must have been a tick edge.
        if (rxclk_en !== 1'b1) rise_bad++;
      end
      prev_valid = rx_valid;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    idle(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic consume();
    @(negedge clk_50m);
    rx_ready = 1'b1;
    @(negedge clk_50m);
    rx_ready = 1'b0;
  endtask

  initial begin
    int         fe0;
    int         ov0;
    int         rise0;
    int         changes;
    int         busy_cyc;
    logic [7:0] rb;
    logic [7:0] fixed4[4];

    n_vec    = 0;
    n_miss   = 0;
    rst      = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b0;
    idle(5);
    rst = 1'b0;
    idle(2);

    // Reset state
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_busy", {31'd0, rx_busy}, 32'd0);
    chk("reset_ferr", {31'd0, rx_frame_err}, 32'd0);
    chk("reset_ovr", {31'd0, rx_overrun}, 32'd0);
    idle(100);

    // 0xA5 with consumer not ready: byte held stable
    fe0 = fe_cyc; ov0 = ov_cyc;
    send_frame(8'hA5, 1'b1);
    chk("a5_valid", {31'd0, rx_valid}, 32'd1);
    chk("a5_data", {24'd0, rx_data}, 32'hA5);
    changes = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk_50m);
      if (rx_valid !== 1'b1 || rx_data !== 8'hA5) changes++;
    end
    chk("a5_hold", changes, 0);
    consume();
    chk("a5_consumed", {31'd0, rx_valid}, 32'd0);
    chk("a5_flags", fe_cyc - fe0 + ov_cyc - ov0, 0);

    // Start-edge glitch of 3 ticks: busy for exactly the mid-sample window
    idle(200);
    fe0 = fe_cyc; ov0 = ov_cyc; rise0 = rise_cnt;
    busy_cyc = 0;
    rx_in = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c == 3 * TICK_DIV) rx_in = 1'b1;
      @(negedge clk_50m);
      if (rx_busy === 1'b1) busy_cyc++;
    end
    chk("glitch_busy_cycles", busy_cyc, MID_TICKS * TICK_DIV);
    chk("glitch_busy_end", {31'd0, rx_busy}, 32'd0);
    chk("glitch_no_valid", rise_cnt - rise0, 0);
    chk("glitch_no_flags", fe_cyc - fe0 + ov_cyc - ov0, 0);

    // Framing error followed by a held-low break, then a good frame
    idle(200);
    fe0 = fe_cyc; rise0 = rise_cnt;
    send_frame(8'h3C, 1'b0);
    idle(2 * BIT_CYC);
    chk("ferr_pulse", fe_cyc - fe0, 1);
    chk("ferr_no_valid", rise_cnt - rise0, 0);
    chk("break_busy", {31'd0, rx_busy}, 32'd1);
    rx_in = 1'b1;
    idle(200);
    chk("break_released", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h55, 1'b1);
    chk("after_break_valid", {31'd0, rx_valid}, 32'd1);
    chk("after_break_data", {24'd0, rx_data}, 32'h55);
    chk("after_break_ferr", fe_cyc - fe0, 1);
    consume();

    // Overrun: two frames back to back with no consumer
    idle(200);
    ov0 = ov_cyc;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_data", {24'd0, rx_data}, 32'h11);
    chk("ovr_pulse", ov_cyc - ov0, 1);
    consume();
    chk("ovr_consumed", {31'd0, rx_valid}, 32'd0);

    // Consumer always ready: random bytes then fixed corners, delivered in order
    idle(200);
    got_q.delete();
    exp_q.delete();
    rise0 = rise_cnt; ov0 = ov_cyc;
    @(negedge clk_50m);
    rx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      send_frame(rb, 1'b1);
      idle($urandom_range(0, 100));
    end
    fixed4[0] = 8'h00; fixed4[1] = 8'hFF; fixed4[2] = 8'h80; fixed4[3] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(fixed4[k]);
      send_frame(fixed4[k], 1'b1);
    end
    idle(500);
    rx_ready = 1'b0;
    chk("stream_count", got_q.size(), exp_q.size());
    chk("stream_rises", rise_cnt - rise0, exp_q.size());
    chk("stream_no_ovr", ov_cyc - ov0, 0);
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk($sformatf("stream_byte%0d", k), {24'd0, got_q[k]}, {24'd0, exp_q[k]});
    end

    // Reset during data bit 4 of 0x5A, then a clean 0xC3
    idle(200);
    fe0 = fe_cyc; ov0 = ov_cyc;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 8'h00);
    rx_in = 1'b1;
    idle(BIT_CYC / 2);
    chk("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk_50m);
    rst = 1'b0;
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    idle(2 * BIT_CYC);
    chk("rst_no_flags", fe_cyc - fe0 + ov_cyc - ov0, 0);
    chk("rst_stays_idle", {31'd0, rx_busy}, 32'd0);
    send_frame(8'hC3, 1'b1);
    chk("c3_valid", {31'd0, rx_valid}, 32'd1);
    chk("c3_data", {24'd0, rx_data}, 32'hC3);
    consume();

    chk("valid_latency", rise_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive end of the serial link whose timing the baud-rate generator provides. Consumes the 16x-oversample enable (rxclk_en) on the 50 MHz domain and deserialises 8N1 frames from the asynchronous rx_in pin. Each received byte goes to a one-entry output register with a valid/ready handshake. Framing errors and overruns are flagged as pulses.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first
OVERSAMPLE, 16, rxclk_en ticks per bit period (must match the baud generator)
MID_SAMPLE, OVERSAMPLE/2, ticks from start-edge detection to the start-bit centre check

Ports:
clk_50m  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
rxclk_en  input  1  one-cycle oversample strobe, 16x baud
rx_in  input  1  asynchronous serial line, idle high
rx_ready  input  1  consumer accepts rx_data when rx_valid=1
rx_data  output  DATA_BITS  last accepted byte, held stable while rx_valid=1
rx_valid  output  1  byte available; held until handshake
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: frame completed while rx_valid=1 and not consumed
rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk_50m. Reset is synchronous and active-high (rst).
- Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, state=IDLE, counters=0, synchroniser flops=1.
- rx_in passes through a 2-flop synchroniser (rx_sync). This adds 2 clk_50m cycles of latency.
- All FSM and counter updates advance only on cycles with rxclk_en=1. Handshake logic runs every cycle.
- Counters: sample_cnt is log2(OVERSAMPLE) bits and wraps 15->0. bit_cnt is log2(DATA_BITS) bits.
- IDLE: on a tick with rx_sync=0, go to START and set sample_cnt=0.
- START: increment sample_cnt each tick. On the MID_SAMPLE-th tick after detection (sample_cnt==MID_SAMPLE-1):
  - rx_sync=0: go to DATA, sample_cnt=0, bit_cnt=0.
  - rx_sync=1: glitch. Return to IDLE with no flags raised.
- DATA: on every OVERSAMPLE-th tick (sample_cnt==OVERSAMPLE-1), shift rx_sync into the MSB of the shift register (LSB-first reception). After bit_cnt==DATA_BITS-1 has been sampled, go to STOP.
- STOP: on the OVERSAMPLE-th tick, sample rx_sync.
  - Sampled 1: frame complete. If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: load rx_data and set rx_valid=1. Otherwise: keep the old rx_data, drop the new byte, pulse rx_overrun. Go to IDLE.
  - Sampled 0: pulse rx_frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick with rx_sync=1, then go to IDLE. This prevents a break condition from re-triggering reception.
- Handshake: in any cycle with rx_valid=1 and rx_ready=1, clear rx_valid, unless a new frame completes in that same cycle; then rx_valid stays 1 with the new data.
- Latency: rx_valid rises 1 clk_50m cycle after the rxclk_en tick that samples the stop bit.
- rx_ready while rx_valid=0 has no effect.
- rst mid-frame: abort the frame immediately and apply reset values. No flag pulse.

Decomposition:
- Shared package/include uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH, 3-bit)
  - UART_DATA_BITS=8, UART_OVERSAMPLE=16
  - CLK_FREQ=50_000_000, BAUD=115200
  - These constants are shared with the baud generator and the future uart_tx.
- One sub-module: sync_2ff (2-flop synchroniser with reset value parameter, reset to 1 here). It is reused for other async inputs.

Test Plan:
Tick period = 27 clk_50m cycles (generator divides 50 MHz by 27); bit = 16 ticks = 432 cycles.
- Send 0xA5 8N1 with rx_ready=0 -> rx_valid=1, rx_data=0xA5, held stable for 1000 cycles. Assert rx_ready 1 cycle -> rx_valid=0 next cycle.
- Low glitch on rx_in lasting 3 ticks (81 cycles) -> rx_busy returns to 0 after MID_SAMPLE ticks; no rx_valid and no flags.
- Send 0x3C with stop bit=0 -> rx_frame_err pulse 1 cycle, rx_valid stays 0. Hold the line low for 2 bit times, release, then send 0x55 -> rx_data=0x55.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=0x11 and rx_valid=1; rx_overrun pulses once at the end of the 0x22 frame.
- rx_ready tied 1; 4 back-to-back frames 0x00, 0xFF, 0x80, 0x01 -> exactly 4 rx_valid pulses with matching data in order.
- Assert rst for 1 cycle during data bit 4 of 0x5A -> all outputs 0 next cycle, rx_busy=0. The following 0xC3 frame is received correctly.
